// File: rtl/cdb_arbiter_pkg.sv
// Shared rv32i types: CDB payload struct and the default functional-unit count.
package rv32i_types;

    localparam int NUM_FU_DEFAULT = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
    } rvfi_data_t;

    typedef struct packed {
        logic [5:0]  pd;
        logic [4:0]  rd;
        logic [31:0] pd_v;
        logic [3:0]  rob_idx;
        logic        br_en;
        logic        br_taken;
        logic [31:0] br_target;
        rvfi_data_t  rvfi_data;
    } fu_cdb_data_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-to-CDB bundle: per-FU done/payload requests in, one-hot ack and broadcast out.
interface cdb_arbiter_if import rv32i_types::*; #(
    parameter int NUM_FU = NUM_FU_DEFAULT
) ();
    localparam int SRC_W = $clog2(NUM_FU);

    logic                          branch_mispredict;
    logic         [NUM_FU-1:0]     fu_done;
    fu_cdb_data_t [NUM_FU-1:0]     fu_data;
    logic         [NUM_FU-1:0]     cdb_ack;
    logic                          cdb_valid;
    fu_cdb_data_t                  cdb_data;
    logic         [SRC_W-1:0]      cdb_src;

    modport slave (
        input  branch_mispredict, fu_done, fu_data,
        output cdb_ack, cdb_valid, cdb_data, cdb_src
    );

    modport master (
        output branch_mispredict, fu_done, fu_data,
        input  cdb_ack, cdb_valid, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req bit searching from ptr upward, wrapping.
module rr_arbiter #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_valid
);
    always_comb begin
        int idx;
        idx       = 0;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        // Walk the search order backwards so the nearest requester overwrites farther ones.
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt       = '0;
                gnt[idx]  = 1'b1;
                gnt_idx   = W'(idx);
                gnt_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter/broadcaster: round-robin grant, flush gating, registered broadcast.
// Define CDB_MISPREDICT_PRIORITY_EN to let br_en requesters (lowest index) bypass round-robin.
module cdb_arbiter import rv32i_types::*; #(
    parameter int NUM_FU = NUM_FU_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    cdb_arbiter_if.slave    bus
);
    localparam int SRC_W = $clog2(NUM_FU);

    logic [SRC_W-1:0]  rr_ptr;
    logic [NUM_FU-1:0] rr_gnt;
    logic [SRC_W-1:0]  rr_idx;
    logic              rr_valid;

    logic [NUM_FU-1:0] sel_gnt;
    logic [SRC_W-1:0]  sel_idx;
    logic              sel_valid;
    logic              grant;

    logic              cdb_valid_q;
    fu_cdb_data_t      cdb_data_q;
    logic [SRC_W-1:0]  cdb_src_q;

    rr_arbiter #(.N(NUM_FU)) u_rr (
        .req       (bus.fu_done),
        .ptr       (rr_ptr),
        .gnt       (rr_gnt),
        .gnt_idx   (rr_idx),
        .gnt_valid (rr_valid)
    );

`ifdef CDB_MISPREDICT_PRIORITY_EN
    always_comb begin
        sel_gnt   = rr_gnt;
        sel_idx   = rr_idx;
        sel_valid = rr_valid;
        // Descending scan leaves the lowest-index mispredicting requester as the winner.
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            if (bus.fu_done[i] && bus.fu_data[i].br_en) begin
                sel_gnt    = '0;
                sel_gnt[i] = 1'b1;
                sel_idx    = SRC_W'(i);
                sel_valid  = 1'b1;
            end
        end
    end
`else
    assign sel_gnt   = rr_gnt;
    assign sel_idx   = rr_idx;
    assign sel_valid = rr_valid;
`endif

    // A flush suppresses the grant entirely, so the FU keeps its result and rr_ptr holds.
    assign grant       = sel_valid && !bus.branch_mispredict && rst_n;
    assign bus.cdb_ack = {NUM_FU{grant}} & sel_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            cdb_valid_q <= 1'b0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else begin
            cdb_valid_q <= grant;
            if (grant) begin
                cdb_data_q <= bus.fu_data[sel_idx];
                cdb_src_q  <= sel_idx;
                rr_ptr     <= (sel_idx == SRC_W'(NUM_FU - 1)) ? '0 : sel_idx + SRC_W'(1);
            end
        end
    end

    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.cdb_src   = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_cdb_arbiter;
    import rv32i_types::*;

    localparam int N  = 4;
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_FU(N)) bus ();

    cdb_arbiter #(.NUM_FU(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference model state: pointer and what the CDB should show.
    int           m_ptr;
    logic         m_valid;
    fu_cdb_data_t m_data;
    int           m_src;

    function automatic void model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
    endfunction

    function automatic int model_grant(input logic [N-1:0] done, input logic [N-1:0] br,
                                       input logic flush, input int ptr);
        if (flush) return -1;
`ifdef CDB_MISPREDICT_PRIORITY_EN
        for (int i = 0; i < N; i++) if (done[i] && br[i]) return i;
`endif
        for (int k = 0; k < N; k++) if (done[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic int cur_grant();
        logic [N-1:0] br;
        for (int i = 0; i < N; i++) br[i] = bus.fu_data[i].br_en;
        if (!rst_n) return -1;
        return model_grant(bus.fu_done, br, bus.branch_mispredict, m_ptr);
    endfunction

    function automatic logic [N-1:0] exp_ack();
        logic [N-1:0] a;
        int g;
        a = '0;
        g = cur_grant();
        if (g >= 0) a[g] = 1'b1;
        return a;
    endfunction

    function automatic fu_cdb_data_t rand_payload();
        fu_cdb_data_t p;
        p.pd                 = 6'($urandom);
        p.rd                 = 5'($urandom);
        p.pd_v               = $urandom;
        p.rob_idx            = 4'($urandom);
        p.br_en              = 1'($urandom_range(0, 1));
        p.br_taken           = 1'($urandom_range(0, 1));
        p.br_target          = $urandom;
        p.rvfi_data.pc       = $urandom;
        p.rvfi_data.inst     = $urandom;
        p.rvfi_data.rd_addr  = 5'($urandom);
        p.rvfi_data.rd_wdata = $urandom;
        return p;
    endfunction

    task automatic clear_inputs();
        bus.fu_done           = '0;
        bus.branch_mispredict = 1'b0;
        for (int i = 0; i < N; i++) bus.fu_data[i] = '0;
    endtask

    // Advance one clock and update the model with whatever was granted this cycle.
    task automatic tick();
        int g;
        g = cur_grant();
        @(posedge clk);
        if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = bus.fu_data[g];
            m_src   = g;
            m_ptr   = (g + 1) % N;
        end else begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        cmp_cnt++;
        if (bus.cdb_valid !== 1'b0 || bus.cdb_ack !== '0) begin
            err_cnt++;
            $display("FAIL reset_idle: valid=%b ack=%b want valid=0 ack=0", bus.cdb_valid, bus.cdb_ack);
        end
        bus.fu_done    = 4'b0010;
        bus.fu_data[1] = rand_payload();
        #1;
        tick();
        cmp_cnt++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_data !== m_data) begin
            err_cnt++;
            $display("FAIL reset_prebcast: valid=%b data=%h want valid=1 data=%h",
                     bus.cdb_valid, bus.cdb_data, m_data);
        end
        rst_n = 1'b0;
        #1;
        cmp_cnt++;
        if (bus.cdb_valid !== 1'b0 || bus.cdb_data !== '0 || bus.cdb_src !== '0 || bus.cdb_ack !== '0) begin
            err_cnt++;
            $display("FAIL reset_async: valid=%b data=%h src=%0d ack=%b want all zero",
                     bus.cdb_valid, bus.cdb_data, bus.cdb_src, bus.cdb_ack);
        end
        @(posedge clk);
        #1;
        bus.fu_done = '0;
        rst_n = 1'b1;
        model_reset();
        #1;
        cmp_cnt++;
        if (bus.cdb_ack !== '0) begin
            err_cnt++;
            $display("FAIL reset_release_ack: ack=%b want 0000", bus.cdb_ack);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want;
        do_reset();
        bus.fu_done = '1;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < N; i++) bus.fu_data[i] = rand_payload();
            #1;
            want = '0;
            want[c % N] = 1'b1;
            cmp_cnt++;
            if (bus.cdb_ack !== want) begin
                err_cnt++;
                $display("FAIL rr_ack[%0d]: ack=%b want %b", c, bus.cdb_ack, want);
            end
            tick();
            cmp_cnt++;
            if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== IW'(c % N) || bus.cdb_data !== m_data) begin
                err_cnt++;
                $display("FAIL rr_bcast[%0d]: valid=%b src=%0d want valid=1 src=%0d",
                         c, bus.cdb_valid, bus.cdb_src, c % N);
            end
        end
        bus.fu_done = '0;
        #1;
    endtask

    task automatic test_single();
        bus.fu_done         = 4'b0100;
        bus.fu_data[2]      = rand_payload();
        bus.fu_data[2].pd_v = 32'h1234;
        #1;
        cmp_cnt++;
        if (bus.cdb_ack !== 4'b0100) begin
            err_cnt++;
            $display("FAIL single_ack: ack=%b want 0100", bus.cdb_ack);
        end
        tick();
        bus.fu_done = '0;
        cmp_cnt++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_data.pd_v !== 32'h1234 || bus.cdb_src !== IW'(2)
            || bus.cdb_data !== m_data) begin
            err_cnt++;
            $display("FAIL single_bcast: valid=%b pd_v=%h src=%0d want 1 00001234 2",
                     bus.cdb_valid, bus.cdb_data.pd_v, bus.cdb_src);
        end
        tick();
        cmp_cnt++;
        if (bus.cdb_valid !== 1'b0 || bus.cdb_src !== IW'(2) || bus.cdb_data.pd_v !== 32'h1234) begin
            err_cnt++;
            $display("FAIL single_idle_hold: valid=%b src=%0d pd_v=%h want 0 2 00001234",
                     bus.cdb_valid, bus.cdb_src, bus.cdb_data.pd_v);
        end
    endtask

    // Runs after test_single, which leaves the pointer at 3.
    task automatic test_wrap();
        bus.fu_done    = 4'b1001;
        bus.fu_data[0] = rand_payload();
        bus.fu_data[3] = rand_payload();
        bus.fu_data[0].br_en = 1'b0;
        bus.fu_data[3].br_en = 1'b0;
        #1;
        cmp_cnt++;
        if (bus.cdb_ack !== 4'b1000) begin
            err_cnt++;
            $display("FAIL wrap_ack3: ack=%b want 1000", bus.cdb_ack);
        end
        tick();
        bus.fu_done[3] = 1'b0;
        #1;
        cmp_cnt++;
        if (bus.cdb_src !== IW'(3) || bus.cdb_ack !== 4'b0001) begin
            err_cnt++;
            $display("FAIL wrap_first: src=%0d ack=%b want src=3 ack=0001", bus.cdb_src, bus.cdb_ack);
        end
        tick();
        bus.fu_done = '0;
        cmp_cnt++;
        if (bus.cdb_src !== IW'(0) || bus.cdb_valid !== 1'b1 || bus.cdb_data !== m_data) begin
            err_cnt++;
            $display("FAIL wrap_second: src=%0d valid=%b want src=0 valid=1", bus.cdb_src, bus.cdb_valid);
        end
    endtask

    task automatic test_flush();
        do_reset();
        bus.fu_done           = 4'b0011;
        bus.fu_data[0]        = rand_payload();
        bus.fu_data[1]        = rand_payload();
        bus.fu_data[0].br_en  = 1'b0;
        bus.fu_data[1].br_en  = 1'b0;
        bus.branch_mispredict = 1'b1;
        #1;
        cmp_cnt++;
        if (bus.cdb_ack !== 4'b0000) begin
            err_cnt++;
            $display("FAIL flush_ack: ack=%b want 0000", bus.cdb_ack);
        end
        tick();
        bus.branch_mispredict = 1'b0;
        #1;
        cmp_cnt++;
        if (bus.cdb_valid !== 1'b0 || bus.cdb_ack !== 4'b0001) begin
            err_cnt++;
            $display("FAIL flush_after: valid=%b ack=%b want valid=0 ack=0001", bus.cdb_valid, bus.cdb_ack);
        end
        tick();
        bus.fu_done = '0;
        cmp_cnt++;
        if (bus.cdb_src !== IW'(0) || bus.cdb_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL flush_resume: src=%0d valid=%b want src=0 valid=1", bus.cdb_src, bus.cdb_valid);
        end
    endtask

    task automatic test_priority();
        logic [N-1:0] want;
        int           want_src;
`ifdef CDB_MISPREDICT_PRIORITY_EN
        want = 4'b1000; want_src = 3;
`else
        want = 4'b0001; want_src = 0;
`endif
        do_reset();
        bus.fu_done = 4'b1011;
        for (int i = 0; i < N; i++) begin
            bus.fu_data[i]       = rand_payload();
            bus.fu_data[i].br_en = (i == 3);
        end
        #1;
        cmp_cnt++;
        if (bus.cdb_ack !== want) begin
            err_cnt++;
            $display("FAIL prio_ack: ack=%b want %b", bus.cdb_ack, want);
        end
        tick();
        bus.fu_done = '0;
        cmp_cnt++;
        if (bus.cdb_src !== IW'(want_src) || bus.cdb_data.br_en !== (want_src == 3)) begin
            err_cnt++;
            $display("FAIL prio_src: src=%0d br_en=%b want src=%0d", bus.cdb_src, bus.cdb_data.br_en, want_src);
        end
    endtask

    task automatic test_random();
        int wait_cnt [N];
        int g;
        logic [N-1:0] want;
        clear_inputs();
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.fu_done[i] && $urandom_range(0, 1) == 1) begin
                    bus.fu_done[i] = 1'b1;
                    bus.fu_data[i] = rand_payload();
                    wait_cnt[i]    = 0;
                end
            end
            bus.branch_mispredict = ($urandom_range(0, 7) == 0);
            #1;
            g    = cur_grant();
            want = exp_ack();
            cmp_cnt++;
            if (bus.cdb_ack !== want) begin
                err_cnt++;
                $display("FAIL rand_ack[%0d]: ack=%b want %b", cyc, bus.cdb_ack, want);
            end
`ifndef CDB_MISPREDICT_PRIORITY_EN
            if (g >= 0) begin
                cmp_cnt++;
                if (wait_cnt[g] > N - 1) begin
                    err_cnt++;
                    $display("FAIL rand_fair[%0d]: fu%0d waited %0d want <= %0d", cyc, g, wait_cnt[g], N - 1);
                end
            end
`endif
            for (int i = 0; i < N; i++)
                if (bus.fu_done[i] && i != g && !bus.branch_mispredict) wait_cnt[i]++;
            tick();
            if (g >= 0) bus.fu_done[g] = 1'b0;
            cmp_cnt++;
            if (bus.cdb_valid !== m_valid || bus.cdb_src !== IW'(m_src) || bus.cdb_data !== m_data) begin
                err_cnt++;
                $display("FAIL rand_bcast[%0d]: valid=%b src=%0d data=%h want valid=%b src=%0d data=%h",
                         cyc, bus.cdb_valid, bus.cdb_src, bus.cdb_data, m_valid, m_src, m_data);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        test_reset();
        test_round_robin();
        test_single();
        test_wrap();
        test_flush();
        test_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
